// File: rtl/mmul_mac_engine.sv
// mmul_mac_engine: iterative C = A*B through one shared MAC; MMUL_SIGNED_EN selects signed arithmetic
module mmul_mac_engine #(
    parameter int M  = 2,
    parameter int K  = 2,
    parameter int N  = 2,
    parameter int W  = 16,
    parameter int OW = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              enable,
    input  logic [M*K*W-1:0]  A,
    input  logic [K*N*W-1:0]  B,
    output logic [M*N*OW-1:0] C,
    output logic              busy,
    output logic              done
);
    localparam int IW = $clog2(M > 1 ? M : 2);
    localparam int JW = $clog2(N > 1 ? N : 2);
    localparam int KW = $clog2(K > 1 ? K : 2);
    localparam int PW = OW > 2 * W ? OW : 2 * W;

    if (M < 1 || K < 1 || N < 1 || OW < 1) begin : g_bad_params
        $error("mmul_mac_engine: M, K, N and OW must all be >= 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       i_q, i_d;
    logic [JW-1:0]       j_q, j_d;
    logic [KW-1:0]       k_q, k_d;
    logic [OW-1:0]       acc_q, acc_d, pe;
    logic [M*K*W-1:0]    a_q, a_d;
    logic [K*N*W-1:0]    b_q, b_d;
    logic [M*N*OW-1:0]   c_q, c_d;
    logic [W-1:0]        ae, be;
    logic [PW-1:0]       px;

    // Fetch the current operand pair and form the full product, extended then fitted to OW
    always_comb begin
        ae = a_q[W*(int'(i_q)*K+int'(k_q)) +: W];
        be = b_q[W*(int'(k_q)*N+int'(j_q)) +: W];
`ifdef MMUL_SIGNED_EN
        px = PW'($signed(ae)) * PW'($signed(be));
`else
        px = PW'(ae) * PW'(be);
`endif
        pe = px[OW-1:0];
    end

    // Next-state: accept in IDLE, one MAC per enabled RUN edge, single-cycle DONE
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        if (state_q == IDLE && start) begin
            a_d     = A;
            b_d     = B;
            c_d     = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            acc_d   = '0;
            state_d = RUN;
        end else if (state_q == RUN && enable) begin
            if (k_q != KW'(K - 1)) begin
                acc_d = acc_q + pe;
                k_d   = k_q + KW'(1);
            end else begin
                c_d[OW*(int'(i_q)*N+int'(j_q)) +: OW] = acc_q + pe;
                acc_d = '0;
                k_d   = '0;
                j_d   = j_q == JW'(N - 1) ? '0 : j_q + JW'(1);
                if (j_q == JW'(N - 1)) begin
                    i_d     = i_q == IW'(M - 1) ? '0 : i_q + IW'(1);
                    state_d = i_q == IW'(M - 1) ? DONE : RUN;
                end
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end

    // State, counters, accumulator, operand latches and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

    assign C    = c_q;
    assign busy = state_q == RUN;
    assign done = state_q == DONE;
endmodule
